// File: rtl/pipe_bist_pkg.sv
// Shared definitions for the pipe BIST master: controller state encoding and
// Galois LFSR tap masks used when PIPE_BIST_LFSR_EN is defined.
package pipe_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    GAP   = 3'd2,
    READ  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Right-shifting Galois tap masks: bit k-1 set for each x^k term.
  localparam logic [63:0] LFSR_TAPS_8  = 64'h0000_0000_0000_00B8; // x^8+x^6+x^5+x^4+1
  localparam logic [63:0] LFSR_TAPS_16 = 64'h0000_0000_0000_B400; // x^16+x^14+x^13+x^11+1
  localparam logic [63:0] LFSR_TAPS_32 = 64'h0000_0000_8020_0003; // x^32+x^22+x^2+x+1

  // Tap mask for a given word width; widths without a listed polynomial
  // return zero and must not be used with the LFSR pattern.
  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      8:       return LFSR_TAPS_8;
      16:      return LFSR_TAPS_16;
      32:      return LFSR_TAPS_32;
      default: return 64'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_bist_pattern.sv
// Pattern generator for the pipe BIST: load captures the first word, step
// advances to the next one. Incrementing counter by default; a maximal-length
// Galois LFSR when PIPE_BIST_LFSR_EN is defined.
module pipe_bist_pattern #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] next_val;

`ifdef PIPE_BIST_LFSR_EN
  import pipe_bist_pkg::*;

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  // An all-zero state would lock the LFSR, so a zero seed starts at 1.
  assign load_val = (seed == '0) ? WIDTH'(1) : seed;
  assign next_val = value[0] ? ((value >> 1) ^ TAPS) : (value >> 1);
`else
  assign load_val = seed;
  assign next_val = value + WIDTH'(1);
`endif

  // Pattern register: load has priority over step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (step) begin
      value <= next_val;
    end
  end

endmodule

// File: rtl/pipe_bist_master.sv
// Pipe BIST master: writes N pattern words into a pipe memory, waits
// GAP_CYCLES idle cycles, reads N words back and counts mismatches.
// Optional build macro PIPE_BIST_LFSR_EN selects an LFSR pattern instead of
// the default seed+i sequence.
module pipe_bist_master
  import pipe_bist_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 4,
  parameter int MEM_DATA_WIDTH = 16,
  parameter int GAP_CYCLES     = 5
) (
  input  logic                      ti_clk,
  input  logic                      ti_rst_n,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH:0]   burst_len,
  input  logic [MEM_DATA_WIDTH-1:0] seed,
  output logic                      ti_data_in_en,
  output logic [MEM_DATA_WIDTH-1:0] ti_data_in,
  output logic                      ti_data_out_en,
  input  logic [MEM_DATA_WIDTH-1:0] ti_data_out,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [MEM_ADDR_WIDTH:0]   err_count,
  output logic [MEM_ADDR_WIDTH-1:0] first_err_idx
);

  localparam int              CW       = MEM_ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   DEPTH    = CW'(2 ** MEM_ADDR_WIDTH);
  localparam logic [7:0]      GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t                      state_q, state_d;
  logic [CW-1:0]               n_q;
  logic [CW-1:0]               n_eff;
  logic [CW-1:0]               idx_q;
  logic [7:0]                  gap_q;
  logic                        rd_valid_q;
  logic [MEM_ADDR_WIDTH-1:0]   cmp_idx_q;
  logic [CW-1:0]               err_q;
  logic [MEM_ADDR_WIDTH-1:0]   first_err_q;
  logic                        start_ok;
  logic                        idx_last;
  logic                        gap_last;
  logic                        wr_en;
  logic                        rd_en;
  logic [MEM_DATA_WIDTH-1:0]   wr_pattern;
  logic [MEM_DATA_WIDTH-1:0]   exp_pattern;

  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign n_eff    = ((burst_len == '0) || (burst_len > DEPTH)) ? DEPTH : burst_len;
  assign idx_last = (idx_q == (n_q - CW'(1)));
  assign gap_last = (gap_q == GAP_LAST);

  // State register.
  // NOTE: sequential blocks use non-blocking (<=) so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge ti_clk) begin
    if (!ti_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe/status decode.
  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    pass    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = WRITE;
      end
      WRITE: begin
        wr_en = 1'b1;
        if (idx_last) state_d = GAP;
      end
      GAP: begin
        if (gap_last) state_d = READ;
      end
      READ: begin
        rd_en = 1'b1;
        if (idx_last) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        pass = (err_q == '0);
        if (start) state_d = WRITE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the effective burst length when a test is accepted.
  always_ff @(posedge ti_clk) begin
    if (!ti_rst_n) begin
      n_q <= '0;
    end else if (start_ok) begin
      n_q <= n_eff;
    end
  end

  // Word index for the write and read bursts, gap timer, read-valid delay.
  always_ff @(posedge ti_clk) begin
    if (!ti_rst_n) begin
      idx_q      <= '0;
      gap_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      gap_q      <= (state_q == GAP) ? gap_q + 8'd1 : 8'd0;
      if (start_ok) begin
        idx_q <= '0;
      end else if (wr_en || rd_en) begin
        idx_q <= idx_last ? '0 : idx_q + CW'(1);
      end
    end
  end

  // Compare returning data one cycle after each read strobe.
  always_ff @(posedge ti_clk) begin
    if (!ti_rst_n) begin
      cmp_idx_q   <= '0;
      err_q       <= '0;
      first_err_q <= '0;
    end else if (start_ok) begin
      cmp_idx_q   <= '0;
      err_q       <= '0;
      first_err_q <= '0;
    end else if (rd_valid_q) begin
      cmp_idx_q <= cmp_idx_q + MEM_ADDR_WIDTH'(1);
      if (ti_data_out != exp_pattern) begin
        err_q <= err_q + CW'(1);
        if (err_q == '0) first_err_q <= cmp_idx_q;
      end
    end
  end

  pipe_bist_pattern #(.WIDTH(MEM_DATA_WIDTH)) u_wr_pattern (
    .clk   (ti_clk),
    .rst_n (ti_rst_n),
    .load  (start_ok),
    .step  (wr_en),
    .seed  (seed),
    .value (wr_pattern)
  );

  pipe_bist_pattern #(.WIDTH(MEM_DATA_WIDTH)) u_exp_pattern (
    .clk   (ti_clk),
    .rst_n (ti_rst_n),
    .load  (start_ok),
    .step  (rd_valid_q),
    .seed  (seed),
    .value (exp_pattern)
  );

  assign ti_data_in_en  = wr_en;
  assign ti_data_in     = wr_en ? wr_pattern : '0;
  assign ti_data_out_en = rd_en;
  assign err_count      = err_q;
  assign first_err_idx  = first_err_q;

endmodule

// File: tb/tb_pipe_bist_master.sv
// Self-checking bench for pipe_bist_master: FIFO loopback memory with optional
// per-word corruption, reference pattern computed from seed and index.
// Honours PIPE_BIST_LFSR_EN for the reference pattern.
module tb_pipe_bist_master;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int GAP   = 5;
  localparam int DEPTH = 16;

  logic          ti_clk = 1'b0;
  logic          ti_rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   burst_len = '0;
  logic [DW-1:0] seed = '0;
  logic          ti_data_in_en;
  logic [DW-1:0] ti_data_in;
  logic          ti_data_out_en;
  logic [DW-1:0] ti_data_out = '0;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_idx;

  int n_checks = 0;
  int n_fails  = 0;

  logic [DW-1:0]    fifo[$];
  int               rd_idx = 0;
  logic [DEPTH-1:0] cmask_g = '0;

  pipe_bist_master #(
    .MEM_ADDR_WIDTH (AW),
    .MEM_DATA_WIDTH (DW),
    .GAP_CYCLES     (GAP)
  ) dut (
    .ti_clk         (ti_clk),
    .ti_rst_n       (ti_rst_n),
    .start          (start),
    .burst_len      (burst_len),
    .seed           (seed),
    .ti_data_in_en  (ti_data_in_en),
    .ti_data_in     (ti_data_in),
    .ti_data_out_en (ti_data_out_en),
    .ti_data_out    (ti_data_out),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_idx  (first_err_idx)
  );

  always #5 ti_clk = ~ti_clk;

  // Loopback pipe memory: writes queue up, reads return the oldest word one
  // cycle later, optionally corrupted at selected read indices.
  always @(posedge ti_clk) begin
    logic [DW-1:0] v;
    if (start && !busy) begin
      fifo.delete();
      rd_idx = 0;
    end else begin
      if (ti_data_in_en) fifo.push_back(ti_data_in);
      if (ti_data_out_en) begin
        v = (fifo.size() > 0) ? fifo.pop_front() : '0;
        if (rd_idx < DEPTH && cmask_g[rd_idx]) v = v ^ 16'h00FF;
        rd_idx++;
        ti_data_out <= v;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word i of the test pattern derived directly from the seed.
  function automatic logic [DW-1:0] ref_pattern(input logic [DW-1:0] sd, input int i);
`ifdef PIPE_BIST_LFSR_EN
    logic [DW-1:0] v;
    v = (sd == '0) ? 16'h0001 : sd;
    for (int k = 0; k < i; k++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
`else
    return DW'((int'(sd) + i) % 65536);
`endif
  endfunction

  // One complete test from start to DONE, with optional start pokes in GAP
  // and READ, followed by protocol, data and result checks.
  task automatic run_test(input logic [AW:0] bl, input logic [DW-1:0] sd,
                          input logic [DEPTH-1:0] cm, input bit poke, input string tag);
    int n, exp_err, exp_first, wr_n, rd_n, first_wr, last_wr, first_rd, last_rd;
    int done_t, overlap, leak, bad;
    bit p1, p2;
    logic [DW-1:0] written[$];
    n = (bl == 0 || int'(bl) > DEPTH) ? DEPTH : int'(bl);
    exp_err = 0; exp_first = 0;
    for (int i = 0; i < n; i++) begin
      if (cm[i]) begin
        if (exp_err == 0) exp_first = i;
        exp_err++;
      end
    end
    wr_n = 0; rd_n = 0; first_wr = -1; last_wr = -1; first_rd = -1; last_rd = -1;
    done_t = -1; overlap = 0; leak = 0; bad = 0; p1 = 0; p2 = 0;
    cmask_g = cm;
    @(negedge ti_clk);
    burst_len = bl; seed = sd; start = 1'b1;
    @(negedge ti_clk);
    start = 1'b0;
    burst_len = AW'($urandom) + 1'b1;
    seed = DW'($urandom);
    check({tag, "/err_cleared"}, err_count, 0);
    check({tag, "/first_idx_cleared"}, first_err_idx, 0);
    for (int t = 0; t < 400; t++) begin
      if (t > 0) @(negedge ti_clk);
      if (ti_data_in_en) begin
        written.push_back(ti_data_in);
        if (first_wr < 0) first_wr = t;
        last_wr = t; wr_n++;
      end
      if (ti_data_out_en) begin
        if (first_rd < 0) first_rd = t;
        last_rd = t; rd_n++;
      end
      if (ti_data_in_en && ti_data_out_en) overlap++;
      if (!ti_data_in_en && ti_data_in != '0) leak++;
      if (done) begin
        done_t = t;
        break;
      end
      start = 1'b0;
      if (poke && !p1 && wr_n == n && !ti_data_in_en) begin
        start = 1'b1; p1 = 1;
      end else if (poke && !p2 && rd_n == 2) begin
        start = 1'b1; p2 = 1;
      end
    end
    start = 1'b0;
    for (int i = 0; i < written.size(); i++) if (written[i] !== ref_pattern(sd, i)) bad++;
    check({tag, "/done_reached"}, done_t >= 0, 1);
    check({tag, "/write_count"}, wr_n, n);
    check({tag, "/read_count"}, rd_n, n);
    check({tag, "/first_write_t"}, first_wr, 0);
    check({tag, "/last_write_t"}, last_wr, n - 1);
    check({tag, "/first_read_t"}, first_rd, n + GAP);
    check({tag, "/last_read_t"}, last_rd, 2 * n + GAP - 1);
    check({tag, "/done_t"}, done_t, 2 * n + GAP + 1);
    check({tag, "/strobe_overlap"}, overlap, 0);
    check({tag, "/data_in_idle_zero"}, leak, 0);
    check({tag, "/write_data"}, bad, 0);
    check({tag, "/err_count"}, err_count, exp_err);
    check({tag, "/first_err_idx"}, first_err_idx, exp_first);
    check({tag, "/pass"}, pass, exp_err == 0);
    check({tag, "/busy_in_done"}, busy, 0);
  endtask

  initial begin
    int k;
    ti_rst_n = 1'b0;
    repeat (3) @(negedge ti_clk);
    check("reset/in_en", ti_data_in_en, 0);
    check("reset/out_en", ti_data_out_en, 0);
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    check("reset/pass", pass, 0);
    check("reset/err_count", err_count, 0);
    ti_rst_n = 1'b1;

    run_test(5'd10, 16'h0001, '0, 1'b0, "loop10");
    run_test(5'd0, 16'hFFFF, '0, 1'b0, "len0_wrap");
    run_test(5'd10, 16'h0100, 16'h0088, 1'b0, "corrupt_3_7");
    run_test(5'd12, DW'($urandom), '0, 1'b1, "restart_pokes");
    run_test(5'd20, 16'hABCD, 16'h8000, 1'b0, "len20_clamp");
    run_test(5'd1, 16'h7FFF, 16'h0001, 1'b0, "len1_err0");

    // Reset arriving on the 4th write of a burst.
    cmask_g = '0;
    @(negedge ti_clk);
    burst_len = 5'd10; seed = DW'($urandom); start = 1'b1;
    @(negedge ti_clk);
    start = 1'b0;
    k = 0;
    for (int t = 0; t < 50 && k < 4; t++) begin
      if (t > 0) @(negedge ti_clk);
      if (ti_data_in_en) k++;
    end
    check("midreset/reached_4th_write", k, 4);
    ti_rst_n = 1'b0;
    @(negedge ti_clk);
    check("midreset/in_en", ti_data_in_en, 0);
    check("midreset/data_in", ti_data_in, 0);
    check("midreset/out_en", ti_data_out_en, 0);
    check("midreset/busy", busy, 0);
    check("midreset/done", done, 0);
    check("midreset/pass", pass, 0);
    check("midreset/err_count", err_count, 0);
    check("midreset/first_err_idx", first_err_idx, 0);
    ti_rst_n = 1'b1;
    @(negedge ti_clk);
    check("midreset/idle_after", {ti_data_in_en, ti_data_out_en, busy}, 0);
    run_test(5'd10, 16'h1234, '0, 1'b0, "after_reset");

    run_test(5'd8, 16'h0000, '0, 1'b0, "seed0");

    for (int r = 0; r < 4; r++) begin
      run_test(5'($urandom_range(0, 31)), DW'($urandom),
               DEPTH'($urandom & $urandom & $urandom), r[0], $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pipe_bist_master.md
PIPE_BIST_MASTER -- requirements
Module: pipe_bist_master

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 4: depth exponent of the pipe memory under test.
REQ-002 SHALL have parameter MEM_DATA_WIDTH, default 16: pipe word width.
REQ-003 SHALL have parameter GAP_CYCLES, default 5: idle cycles between the write burst and the read burst, legal range 1..255.
REQ-004 SHALL have port ti_clk, input, 1 bit: sole clock; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port ti_rst_n, input, 1 bit: synchronous active-low reset, sampled on the ti_clk rising edge.
REQ-006 SHALL have port start, input, 1 bit: single-cycle request to run one test; ignored unless in IDLE or DONE.
REQ-007 SHALL have port burst_len, input, MEM_ADDR_WIDTH+1 bits: word count, captured on start.
REQ-008 SHALL have port seed, input, MEM_DATA_WIDTH bits: first pattern word, captured on start.
REQ-009 SHALL have port ti_data_in_en, output, 1 bit: pipe-in write strobe.
REQ-010 SHALL have port ti_data_in, output, MEM_DATA_WIDTH bits: pipe-in write data.
REQ-011 SHALL have port ti_data_out_en, output, 1 bit: pipe-out read strobe.
REQ-012 SHALL have port ti_data_out, input, MEM_DATA_WIDTH bits: pipe-out read data, valid exactly 1 cycle after ti_data_out_en.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-014 SHALL have port done, output, 1 bit: high while in DONE.
REQ-015 SHALL have port pass, output, 1 bit: high in DONE when err_count==0.
REQ-016 SHALL have port err_count, output, MEM_ADDR_WIDTH+1 bits: number of mismatched words.
REQ-017 SHALL have port first_err_idx, output, MEM_ADDR_WIDTH bits: index of the first mismatched word; 0 if none.

Function
REQ-018 SHALL use states IDLE, WRITE, GAP, READ, DRAIN, DONE; start moves IDLE or DONE to WRITE on the next edge.
REQ-019 SHALL compute effective length N = burst_len, with 0 or any value >2^MEM_ADDR_WIDTH mapped to 2^MEM_ADDR_WIDTH.
REQ-020 SHALL in WRITE assert ti_data_in_en for exactly N consecutive cycles with ti_data_in = pattern(i), i=0..N-1, then enter GAP.
REQ-021 SHALL in GAP hold all strobes low for exactly GAP_CYCLES cycles, then enter READ.
REQ-022 SHALL in READ assert ti_data_out_en for exactly N consecutive cycles, then enter DRAIN for 1 cycle, then DONE.
REQ-023 SHALL compare ti_data_out in the cycle after each read strobe against pattern(i); on mismatch increment err_count and latch first_err_idx only on the first mismatch.
REQ-024 SHALL generate pattern(i) = seed + i modulo 2^MEM_DATA_WIDTH when PIPE_BIST_LFSR_EN is undefined.
REQ-025 SHALL on start from DONE clear err_count and first_err_idx in the same edge that enters WRITE.
REQ-026 SHALL ignore start while busy; burst_len and seed changes while busy SHALL have no effect.
REQ-027 SHALL never assert ti_data_in_en and ti_data_out_en in the same cycle.
REQ-028 SHALL drive ti_data_in to 0 whenever ti_data_in_en is low.

Reset
REQ-029 SHALL on ti_rst_n low force state IDLE and drive all outputs to 0, including when the reset arrives mid-burst; no strobe SHALL be asserted in the cycle after reset is sampled.

Configuration
REQ-030 SHALL, with macro PIPE_BIST_LFSR_EN defined, generate pattern(0)=seed (seed 0 replaced by 1) and pattern(i+1) = a maximal-length Galois LFSR step of pattern(i), with the polynomial fixed per MEM_DATA_WIDTH (16-bit: x^16+x^14+x^13+x^11+1); without the macro, REQ-024 applies and no LFSR logic is synthesized.

Structure
REQ-031 SHALL place the state enumeration and the LFSR tap constants in a shared package, pipe_bist_pkg.
REQ-032 SHALL use one sub-module, pipe_bist_pattern, which is instantiated twice (one for write, one for expected read data) and has load, step, seed and value.

Verification
REQ-033 Loopback memory, burst_len=10, seed=1: write data 1..10, 5 idle cycles, 10 reads, done=1, pass=1, err_count=0.
REQ-034 burst_len=0: exactly 16 writes and 16 reads, seed=0xFFFF wraps to 0x0000 at i=1, pass=1.
REQ-035 Memory corrupts word 3 and word 7: err_count=2, first_err_idx=3, pass=0.
REQ-036 ti_rst_n low for 1 cycle at the 4th write: next cycle IDLE with all outputs 0; a new start runs the full test cleanly.
REQ-037 start pulses during GAP and READ: ignored, strobe counts unchanged; start in DONE restarts and clears err_count.
REQ-038 PIPE_BIST_LFSR_EN defined, seed=0: pattern begins 0x0001 followed by the LFSR sequence; loopback gives pass=1.
